// File: rtl/multitap_delay.sv
// multitap_delay: circular sample buffer with NTAPS delayed read taps; MULTITAP_MIX_EN adds a dry+taps mix output
module multitap_delay #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8,
  parameter int NTAPS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [D_WIDTH-1:0]         mic_signal,
  input  logic [NTAPS*A_WIDTH-1:0]   offset,
  output logic [NTAPS*D_WIDTH-1:0]   delayed_signal,
  output logic                       out_valid,
  output logic                       filled
`ifdef MULTITAP_MIX_EN
  ,
  output logic [D_WIDTH+$clog2(NTAPS+1)-1:0] mixed_signal
`endif
);
  localparam int DEPTH = 2**A_WIDTH;
  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH:0] fill_cnt_q, fill_cnt_d;
  logic [NTAPS*D_WIDTH-1:0] delayed_q, delayed_d;
  logic out_valid_q;
  logic [D_WIDTH-1:0] tap_val [NTAPS];
  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic [A_WIDTH-1:0] d;
    logic [A_WIDTH-1:0] rd_addr;
    assign d = offset[k*A_WIDTH +: A_WIDTH];
    assign rd_addr = wr_ptr_q - d;
    assign tap_val[k] = ({1'b0, d} > fill_cnt_q) ? '0 : (d == '0) ? mic_signal : mem_q[rd_addr];
  end
  // next-state: pointer advance, saturating fill count, packed tap values
  always_comb begin
    wr_ptr_d = wr_ptr_q + A_WIDTH'(en);
    fill_cnt_d = en ? fill_cnt_q + (A_WIDTH+1)'(!fill_cnt_q[A_WIDTH]) : fill_cnt_q;
    delayed_d = delayed_q;
    for (int i = 0; i < NTAPS; i++) delayed_d[i*D_WIDTH +: D_WIDTH] = en ? tap_val[i] : delayed_q[i*D_WIDTH +: D_WIDTH];
  end
  // sample buffer write; contents are never cleared, the fill mask hides stale data
  always_ff @(posedge clk) begin
    if (en && !rst) mem_q[wr_ptr_q] <= mic_signal;
  end
  // control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_cnt_q <= '0;
      delayed_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      delayed_q <= delayed_d;
      out_valid_q <= en;
    end
  end
  assign delayed_signal = delayed_q;
  assign out_valid = out_valid_q;
  assign filled = fill_cnt_q[A_WIDTH];
`ifdef MULTITAP_MIX_EN
  localparam int M_WIDTH = D_WIDTH + $clog2(NTAPS+1);
  logic [M_WIDTH-1:0] mixed_q, mixed_d;
  // dry sample plus every masked tap of the same strobe
  always_comb begin
    mixed_d = M_WIDTH'(mic_signal);
    for (int i = 0; i < NTAPS; i++) mixed_d = mixed_d + M_WIDTH'(tap_val[i]);
  end
  // mix register, updated alongside the taps
  always_ff @(posedge clk) begin
    if (rst) mixed_q <= '0;
    else if (en) mixed_q <= mixed_d;
  end
  assign mixed_signal = mixed_q;
`endif
endmodule

// File: tb/tb_multitap_delay.sv
// tb_multitap_delay: directed self-checking bench for multitap_delay (A_WIDTH=4, NTAPS=2)
module tb_multitap_delay;
  logic clk, rst, en;
  logic [7:0] mic_signal;
  logic [7:0] offset;
  logic [15:0] delayed_signal;
  logic out_valid, filled;
  int checks = 0;
  int failures = 0;
`ifdef MULTITAP_MIX_EN
  logic [9:0] mixed_signal;
`endif
  multitap_delay #(.A_WIDTH(4), .D_WIDTH(8), .NTAPS(2)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mic_signal(mic_signal),
    .offset(offset),
    .delayed_signal(delayed_signal),
    .out_valid(out_valid),
    .filled(filled)
`ifdef MULTITAP_MIX_EN
    ,
    .mixed_signal(mixed_signal)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic e, input logic [7:0] m);
    en = e;
    mic_signal = m;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    mic_signal = '0;
    offset = '0;
    do_reset();
    chk("rst_delayed", delayed_signal, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_filled", filled, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'd0);
      chk("idle_delayed", delayed_signal, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_filled", filled, 0);
    end
    offset = {4'd3, 4'd0};
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 8'(n + 1));
      chk("basic_tap0", delayed_signal[7:0], n + 1);
      chk("basic_tap1", delayed_signal[15:8], n >= 3 ? n - 2 : 0);
      chk("basic_valid", out_valid, 1);
      chk("basic_filled", filled, n >= 15 ? 1 : 0);
    end
    step(1'b0, 8'd0);
    chk("basic_hold_valid", out_valid, 0);
    chk("basic_hold_tap0", delayed_signal[7:0], 20);
    chk("basic_hold_tap1", delayed_signal[15:8], 17);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      offset = {4'd0, 4'd2};
      step(1'b1, 8'(10 * (i + 1)));
      chk("sparse_tap0", delayed_signal[7:0], i >= 2 ? 10 * (i - 1) : 0);
      chk("sparse_tap1", delayed_signal[15:8], 10 * (i + 1));
      chk("sparse_valid", out_valid, 1);
      offset = {4'd1, 4'd7};
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 8'hEE);
        chk("sparse_idle_valid", out_valid, 0);
        chk("sparse_idle_tap0", delayed_signal[7:0], i >= 2 ? 10 * (i - 1) : 0);
        chk("sparse_idle_tap1", delayed_signal[15:8], 10 * (i + 1));
      end
    end
    do_reset();
    chk("wrap_filled_init", filled, 0);
    offset = {4'd1, 4'd15};
    for (int n = 0; n <= 40; n++) begin
      step(1'b1, 8'(n));
      chk("wrap_tap0", delayed_signal[7:0], n >= 15 ? n - 15 : 0);
      chk("wrap_tap1", delayed_signal[15:8], n >= 1 ? n - 1 : 0);
      chk("wrap_filled", filled, n >= 15 ? 1 : 0);
    end
    do_reset();
    for (int n = 0; n < 30; n++) begin
      offset = {4'd0, n < 20 ? 4'd5 : 4'd1};
      step(1'b1, 8'(100 + n));
      chk("ofs_tap0", delayed_signal[7:0], n < 5 ? 0 : n < 20 ? 95 + n : 99 + n);
      chk("ofs_tap1", delayed_signal[15:8], 100 + n);
    end
    chk("ofs_filled", filled, 1);
    rst = 1'b1;
    step(1'b1, 8'd99);
    rst = 1'b0;
    chk("rst_en_delayed", delayed_signal, 0);
    chk("rst_en_valid", out_valid, 0);
    chk("rst_en_filled", filled, 0);
    step(1'b1, 8'd50);
    chk("post_rst_tap0", delayed_signal[7:0], 0);
    chk("post_rst_tap1", delayed_signal[15:8], 50);
    chk("post_rst_valid", out_valid, 1);
    step(1'b1, 8'd60);
    chk("post_rst_tap0_b", delayed_signal[7:0], 50);
    chk("post_rst_filled", filled, 0);
`ifdef MULTITAP_MIX_EN
    do_reset();
    chk("mix_rst", mixed_signal, 0);
    offset = {4'd2, 4'd1};
    for (int n = 0; n < 5; n++) begin
      step(1'b1, 8'd255);
      chk("mix_sum", mixed_signal, n == 0 ? 255 : n == 1 ? 510 : 765);
      chk("mix_tap0", delayed_signal[7:0], n >= 1 ? 255 : 0);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
